config_frame_mem_dbuf: RTL and testbench
========================================

// Module: config_frame_mem_dbuf
// PURPOSE
//  Next-generation tile configuration memory: a flip-flop frame store replacing per-tile latch config memories.
//  Frames load from the column FrameData/FrameStrobe bus into a shadow store. A Commit handshake then copies them atomically to the active ConfigBits.
//  Adds strobe-error detection and optional frame readback. One instance per tile; it drives all switch-matrix/BEL config bits.
// PARAMETERS
//  MaxFramesPerCol   20  width of FrameStrobe (frames per column)
//  FrameBitsPerRow   32  bits per frame (FrameData/ReadData width)
//  NoConfigBits      70  config bits used by tile; must be 1..MaxFramesPerCol*FrameBitsPerRow (elab-time check)
//  localparam NoFrames = ceil(NoConfigBits/FrameBitsPerRow); FrameIdxW = clog2(MaxFramesPerCol)
// PORTS
//  CLK          in   1                clock; all state on rising edge
//  RST          in   1                synchronous reset, active-high
//  FrameData    in   FrameBitsPerRow  frame write data
//  FrameStrobe  in   MaxFramesPerCol  one-hot frame write select, sampled each edge
//  Commit       in   1                request shadow->active copy (single-cycle pulse)
//  CommitDone   out  1                one-cycle pulse: active store updated
//  Dirty        out  1                shadow written since last completed copy
//  StrobeError  out  1                sticky: >1 FrameStrobe bit seen
//  ReadEn       in   1                readback request
//  ReadFrame    in   FrameIdxW        readback frame index
//  ReadData     out  FrameBitsPerRow  readback data (shadow store)
//  ReadValid    out  1                one-cycle pulse, ReadData valid
//  ConfigBits   out  NoConfigBits     active config; bit i = active[i/FrameBitsPerRow][i%FrameBitsPerRow]
// BEHAVIOUR
//  Reset: shadow, active, ConfigBits, ReadData = 0; CommitDone, Dirty, StrobeError, ReadValid = 0; FSM->IDLE.
//  Reset mid-commit aborts the copy; nothing is partially committed.
//  Write: at edge with exactly one FrameStrobe[f] set and f<NoFrames: shadow[f]<=FrameData, Dirty<=1.
//   f>=NoFrames: ignored, no error. 0 bits set: no-op. >=2 bits set: no write, StrobeError<=1 until RST.
//   Bits of the last frame beyond NoConfigBits are not stored.
//  Commit FSM: IDLE -Commit-> COPY -> DONE -> IDLE (one edge each).
//   COPY edge: active<=shadow value before that edge; Dirty<=0 unless a write lands on the same edge (then stays 1).
//   DONE: CommitDone=1 for exactly one cycle.
//   A write on the edge that samples Commit (IDLE) is included in the copy.
//   Commit while in COPY/DONE: ignored, not queued.
//   ConfigBits changes only on the COPY edge. Latency Commit->ConfigBits = 2 edges; Commit->CommitDone = 2 edges.
//  Readback: ReadEn sampled at edge t; ReadData/ReadValid registered, valid cycle after t. ReadValid high 1 cycle.
//   ReadFrame>=NoFrames returns 0. Read and write of the same frame on the same edge returns the old data.
//   Back-to-back reads: one result per cycle.
// CONFIGURATION
//  CONFIG_READBACK_EN defined: readback path as above.
//  Undefined: no read mux/registers; ReadData=0, ReadValid=0 always. ReadEn/ReadFrame ignored; ports retained.
// STRUCTURE
//  Shared package config_mem_pkg:
//   commit-state enum {IDLE,COPY,DONE}; clog2 function; one-hot check function (returns valid + index).
//  Sub-module config_frame_reg: one shadow+active frame pair (width param, write-enable, copy-enable).
//   Instantiated NoFrames times via generate.
//  Top level holds: strobe decode/error, commit FSM, Dirty, readback mux.
// TESTING (FrameBitsPerRow=32, MaxFramesPerCol=20, NoConfigBits=70 -> 3 frames)
//  1 Write frames 0..2 = 0xDEADBEEF,0x12345678,0xFFFFFFFF, Commit
//    -> ConfigBits==0 until COPY edge; then ConfigBits[69:0]=={6'h3F,32'h12345678,32'hDEADBEEF};
//       CommitDone pulses once; Dirty 1->0.
//  2 FrameStrobe=20'h00005 with FrameData=0xA5A5A5A5
//    -> no frame changes, StrobeError=1; stays 1 after more valid writes; cleared only by RST.
//  3 Commit, then a write to frame 1 (0x0BADF00D) on the COPY edge
//    -> ConfigBits keeps old frame 1, Dirty stays 1; second Commit then applies 0x0BADF00D.
//  4 [readback] ReadEn, ReadFrame=1 after writing 0xCAFEF00D -> next cycle ReadData=0xCAFEF00D, ReadValid=1 for 1 cycle;
//    ReadFrame=5 -> ReadData=0; undefined macro -> ReadValid never 1.
//  5 Assert RST during COPY -> all outputs 0 next edge, no CommitDone, ConfigBits==0.
//  6 Strobe frame 10 (>=NoFrames) with 0xFFFFFFFF -> no state change, Dirty and StrobeError stay 0.

Source files
------------

// File: rtl/config_mem_pkg.sv
// Shared types and helpers for the tile configuration frame memory:
// commit-state enum, a constant clog2, and a one-hot strobe checker.
package config_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DONE
    } commit_state_t;

    // Widest strobe vector the one-hot checker accepts, and its index width.
    localparam int OneHotMaxW = 64;
    localparam int OneHotIdxW = 6;

    typedef struct packed {
        logic                  valid;
        logic                  multi;
        logic [OneHotIdxW-1:0] index;
    } onehot_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Classifies a strobe vector: exactly one bit set (valid, with its
    // index), or more than one bit set (multi). Zero bits gives neither.
    function automatic onehot_t onehot_check(input logic [OneHotMaxW-1:0] vec);
        onehot_t res;
        int      count;
        res   = '0;
        count = 0;
        for (int i = 0; i < OneHotMaxW; i++) begin
            if (vec[i]) begin
                count     = count + 1;
                res.index = OneHotIdxW'(i);
            end
        end
        res.valid = (count == 1);
        res.multi = (count > 1);
        return res;
    endfunction

endpackage

// File: rtl/config_frame_reg.sv
// One configuration frame: a shadow register loaded from the frame bus
// and an active register that takes the shadow value on a commit copy.
module config_frame_reg #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             copy_en,
    input  logic [Width-1:0] wr_data,
    output logic [Width-1:0] shadow,
    output logic [Width-1:0] active
);

    // Shadow captures bus data; active copies the pre-edge shadow value.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr_en) begin
                shadow <= wr_data;
            end
            if (copy_en) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: rtl/config_frame_mem_dbuf.sv
// Double-buffered tile configuration frame store. Frames load from the
// column FrameData/FrameStrobe bus into shadow registers; a Commit
// handshake copies every shadow frame to the active ConfigBits at once.
// Optional frame readback of the shadow store is enabled by defining
// CONFIG_READBACK_EN; otherwise ReadData/ReadValid are tied to zero.
module config_frame_mem_dbuf
    import config_mem_pkg::*;
#(
    parameter  int MaxFramesPerCol = 20,
    parameter  int FrameBitsPerRow = 32,
    parameter  int NoConfigBits    = 70,
    localparam int NoFrames        = (NoConfigBits + FrameBitsPerRow - 1) / FrameBitsPerRow,
    localparam int FrameIdxW       = (clog2(MaxFramesPerCol) > 0) ? clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       Commit,
    output logic                       CommitDone,
    output logic                       Dirty,
    output logic                       StrobeError,
    input  logic                       ReadEn,
    input  logic [FrameIdxW-1:0]       ReadFrame,
    output logic [FrameBitsPerRow-1:0] ReadData,
    output logic                       ReadValid,
    output logic [NoConfigBits-1:0]    ConfigBits
);

    // The last frame only stores the bits that map onto ConfigBits.
    localparam int LastW = NoConfigBits - (NoFrames - 1) * FrameBitsPerRow;

    if (NoConfigBits < 1 || NoConfigBits > MaxFramesPerCol * FrameBitsPerRow) begin : g_bad_size
        $error("config_frame_mem_dbuf: NoConfigBits out of range");
    end
    if (MaxFramesPerCol > OneHotMaxW) begin : g_bad_strobe
        $error("config_frame_mem_dbuf: MaxFramesPerCol too wide for strobe checker");
    end

    onehot_t             strobe_chk;
    logic                wr_hit;
    logic [NoFrames-1:0] wr_en;
    logic                copy_en;
    commit_state_t       state_q;
    commit_state_t       state_d;

`ifdef CONFIG_READBACK_EN
    logic [FrameBitsPerRow-1:0] shadow_word [NoFrames];
    logic [FrameBitsPerRow-1:0] read_mux;
`endif

    // Decode the strobe: a single in-range bit selects one frame to write.
    always_comb begin
        strobe_chk = onehot_check(OneHotMaxW'(FrameStrobe));
        wr_hit     = strobe_chk.valid && (int'(strobe_chk.index) < NoFrames);
        wr_en      = '0;
        for (int f = 0; f < NoFrames; f++) begin
            if (wr_hit && (int'(strobe_chk.index) == f)) begin
                wr_en[f] = 1'b1;
            end
        end
    end

    // Sticky strobe error and the shadow-dirty flag; a write landing on
    // the copy edge is not part of that copy, so it keeps Dirty set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            StrobeError <= 1'b0;
            Dirty       <= 1'b0;
        end else begin
            if (strobe_chk.multi) begin
                StrobeError <= 1'b1;
            end
            if (copy_en) begin
                Dirty <= wr_hit;
            end else if (wr_hit) begin
                Dirty <= 1'b1;
            end
        end
    end

    // Commit state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit sequencing: one edge to copy, one cycle to announce it.
    always_comb begin
        state_d    = state_q;
        copy_en    = 1'b0;
        CommitDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (Commit) begin
                    state_d = COPY;
                end
            end
            COPY: begin
                copy_en = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                CommitDone = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar f = 0; f < NoFrames; f++) begin : g_frame
        localparam int W = (f == NoFrames - 1) ? LastW : FrameBitsPerRow;
        logic [W-1:0] shadow_bits;

        config_frame_reg #(
            .Width(W)
        ) u_reg (
            .clk    (CLK),
            .rst    (RST),
            .wr_en  (wr_en[f]),
            .copy_en(copy_en),
            .wr_data(FrameData[W-1:0]),
            .shadow (shadow_bits),
            .active (ConfigBits[f*FrameBitsPerRow +: W])
        );

`ifdef CONFIG_READBACK_EN
        assign shadow_word[f] = (FrameBitsPerRow)'(shadow_bits);
`else
        logic unused_shadow;
        assign unused_shadow = ^shadow_bits;
`endif
    end

`ifdef CONFIG_READBACK_EN
    // Select the requested shadow frame; out-of-range indices read zero.
    always_comb begin
        read_mux = '0;
        for (int f = 0; f < NoFrames; f++) begin
            if (int'(ReadFrame) == f) begin
                read_mux = shadow_word[f];
            end
        end
    end

    // Register the readback result; one result per requesting edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ReadData  <= '0;
            ReadValid <= 1'b0;
        end else begin
            ReadValid <= ReadEn;
            if (ReadEn) begin
                ReadData <= read_mux;
            end
        end
    end
`else
    logic unused_read;
    assign unused_read = ^{ReadEn, ReadFrame};
    assign ReadData    = '0;
    assign ReadValid   = 1'b0;
`endif

endmodule

// File: tb/tb_config_frame_mem_dbuf.sv
// Self-checking bench for config_frame_mem_dbuf (3-frame configuration).
// Follows CONFIG_READBACK_EN the same way the design does.
module tb_config_frame_mem_dbuf;

    localparam int NF  = 3;
    localparam int NCB = 70;
    localparam logic [69:0] Cfg1 = 70'h3F_12345678_DEADBEEF;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        Commit;
    logic        CommitDone;
    logic        Dirty;
    logic        StrobeError;
    logic        ReadEn;
    logic [4:0]  ReadFrame;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic [69:0] ConfigBits;

    int checks = 0;
    int errors = 0;

    // Reference model: frame arrays plus a commit countdown.
    logic [31:0] m_shadow [NF];
    logic [31:0] m_active [NF];
    logic        m_dirty;
    logic        m_err;
    logic        m_rv;
    logic [31:0] m_rd;
    int          m_phase;

    typedef struct {
        logic        rst;
        logic [19:0] strobe;
        logic [31:0] data;
        logic        commit;
        logic        exp_dirty;
        logic        exp_err;
        logic        exp_done;
        logic [69:0] exp_cfg;
    } vec_t;

    vec_t vecs [10];

    config_frame_mem_dbuf dut (
        .CLK        (CLK),
        .RST        (RST),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .Commit     (Commit),
        .CommitDone (CommitDone),
        .Dirty      (Dirty),
        .StrobeError(StrobeError),
        .ReadEn     (ReadEn),
        .ReadFrame  (ReadFrame),
        .ReadData   (ReadData),
        .ReadValid  (ReadValid),
        .ConfigBits (ConfigBits)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] frame_mask(input int f);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = ((f * 32 + i) < NCB);
        end
        return m;
    endfunction

    function automatic logic [69:0] exp_cfg();
        logic [69:0] c;
        for (int i = 0; i < NCB; i++) begin
            c[i] = m_active[i / 32][i % 32];
        end
        return c;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin
            m_shadow[f] = '0;
            m_active[f] = '0;
        end
        m_dirty = 1'b0;
        m_err   = 1'b0;
        m_rv    = 1'b0;
        m_rd    = '0;
        m_phase = 0;
    endtask

    // Advance the model by one rising edge using the inputs held there.
    task automatic ref_edge();
        logic [31:0] old_sh [NF];
        logic        wrote;
        logic        copied;
        int          ones;
        int          idx;
        if (RST) begin
            model_reset();
            return;
        end
        old_sh = m_shadow;
`ifdef CONFIG_READBACK_EN
        m_rv = ReadEn;
        if (ReadEn) begin
            m_rd = '0;
            for (int f = 0; f < NF; f++) begin
                if (int'(ReadFrame) == f) m_rd = old_sh[f];
            end
        end
`endif
        copied = (m_phase == 1);
        if (copied) m_active = old_sh;
        case (m_phase)
            0: if (Commit) m_phase = 1;
            1: m_phase = 2;
            default: m_phase = 0;
        endcase
        ones  = $countones(FrameStrobe);
        wrote = 1'b0;
        idx   = 0;
        if (ones == 1) begin
            for (int i = 0; i < 20; i++) begin
                if (FrameStrobe[i]) idx = i;
            end
            if (idx < NF) begin
                m_shadow[idx] = FrameData & frame_mask(idx);
                wrote = 1'b1;
            end
        end
        if (ones > 1) m_err = 1'b1;
        if (copied) m_dirty = wrote;
        else if (wrote) m_dirty = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    task automatic compareModel();
        checkOutput("model_cfg", ConfigBits, exp_cfg());
        checkBit("model_done", CommitDone, (m_phase == 2));
        checkBit("model_dirty", Dirty, m_dirty);
        checkBit("model_err", StrobeError, m_err);
        checkBit("model_rvalid", ReadValid, m_rv);
        checkOutput("model_rdata", 70'(ReadData), 70'(m_rd));
    endtask

    // Drive one cycle of inputs, take the edge, then compare against the model.
    task automatic applyStimulus(input logic rst, input logic [19:0] strobe, input logic [31:0] data,
                                 input logic commit, input logic ren, input logic [4:0] rframe);
        RST         = rst;
        FrameStrobe = strobe;
        FrameData   = data;
        Commit      = commit;
        ReadEn      = ren;
        ReadFrame   = rframe;
        @(posedge CLK);
        ref_edge();
        #1;
        compareModel();
    endtask

    initial begin
        logic [19:0] s;
        int          a;
        int          b;
        int          r;

        model_reset();
        vecs[0] = '{1'b0, 20'h00001, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 70'h0};
        vecs[1] = '{1'b0, 20'h00002, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 70'h0};
        vecs[2] = '{1'b0, 20'h00004, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 70'h0};
        vecs[3] = '{1'b0, 20'h00000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 70'h0};
        vecs[4] = '{1'b0, 20'h00000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, Cfg1};
        vecs[5] = '{1'b0, 20'h00000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, Cfg1};
        vecs[6] = '{1'b0, 20'h00400, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, Cfg1};
        vecs[7] = '{1'b0, 20'h00005, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, Cfg1};
        vecs[8] = '{1'b0, 20'h00001, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, Cfg1};
        vecs[9] = '{1'b1, 20'h00000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 70'h0};

        applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, '0, '0, 1'b0, 1'b0, '0);
        checkOutput("reset_cfg", ConfigBits, 70'h0);
        checkBit("reset_done", CommitDone, 1'b0);
        checkBit("reset_dirty", Dirty, 1'b0);
        checkBit("reset_err", StrobeError, 1'b0);
        checkBit("reset_rvalid", ReadValid, 1'b0);
        checkOutput("reset_rdata", 70'(ReadData), 70'h0);

        // Table: write/commit, out-of-range strobe, multi-bit strobe, reset.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].strobe, vecs[i].data, vecs[i].commit, 1'b0, '0);
            checkBit($sformatf("vec%0d_dirty", i), Dirty, vecs[i].exp_dirty);
            checkBit($sformatf("vec%0d_err", i), StrobeError, vecs[i].exp_err);
            checkBit($sformatf("vec%0d_done", i), CommitDone, vecs[i].exp_done);
            checkOutput($sformatf("vec%0d_cfg", i), ConfigBits, vecs[i].exp_cfg);
        end

        // Write on the copy edge misses that copy; Commit during DONE is dropped.
        applyStimulus(1'b0, 20'h1, 32'h11111111, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 20'h2, 32'h22222222, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 20'h2, 32'h0BADF00D, 1'b0, 1'b0, '0);
        checkOutput("t3_cfg_old", ConfigBits, 70'h0_22222222_11111111);
        checkBit("t3_dirty_kept", Dirty, 1'b1);
        checkBit("t3_done", CommitDone, 1'b1);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b1, 1'b0, '0);
        checkBit("t3_done_once", CommitDone, 1'b0);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b0, 1'b0, '0);
        checkBit("t3_no_queued_commit", CommitDone, 1'b0);
        checkOutput("t3_cfg_hold", ConfigBits, 70'h0_22222222_11111111);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("t3_cfg_new", ConfigBits, 70'h0_0BADF00D_11111111);
        checkBit("t3_dirty_clear", Dirty, 1'b0);

        // Readback: hit, out-of-range, same-edge write, back-to-back.
        applyStimulus(1'b0, 20'h2, 32'hCAFEF00D, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b0, 1'b1, 5'd1);
`ifdef CONFIG_READBACK_EN
        checkBit("t4_rvalid", ReadValid, 1'b1);
        checkOutput("t4_rdata", 70'(ReadData), 70'hCAFEF00D);
`else
        checkBit("t4_rvalid_off", ReadValid, 1'b0);
        checkOutput("t4_rdata_off", 70'(ReadData), 70'h0);
`endif
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b0, 1'b1, 5'd5);
        checkOutput("t4_rdata_oor", 70'(ReadData), 70'h0);
        applyStimulus(1'b0, 20'h2, 32'h13572468, 1'b0, 1'b1, 5'd1);
`ifdef CONFIG_READBACK_EN
        checkOutput("t4_rdata_old", 70'(ReadData), 70'hCAFEF00D);
`endif
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b0, 1'b1, 5'd1);
`ifdef CONFIG_READBACK_EN
        checkOutput("t4_rdata_b2b", 70'(ReadData), 70'h13572468);
        checkBit("t4_rvalid_b2b", ReadValid, 1'b1);
`endif
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b0, 1'b0, '0);
        checkBit("t4_rvalid_drop", ReadValid, 1'b0);

        // Reset on the copy edge aborts the commit entirely.
        applyStimulus(1'b0, 20'h1, 32'hFFFF0000, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 20'h0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("t5_cfg", ConfigBits, 70'h0);
        checkBit("t5_done", CommitDone, 1'b0);
        checkBit("t5_dirty", Dirty, 1'b0);
        applyStimulus(1'b0, 20'h0, 32'h0, 1'b0, 1'b0, '0);
        checkBit("t5_done_after", CommitDone, 1'b0);
        checkOutput("t5_cfg_after", ConfigBits, 70'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 5) begin
                s = '0;
            end else if (r == 5) begin
                a = int'($urandom_range(0, 19));
                b = (a + 1 + int'($urandom_range(0, 18))) % 20;
                s = (20'd1 << a) | (20'd1 << b);
            end else if (r < 13) begin
                s = 20'd1 << $urandom_range(0, 2);
            end else begin
                s = 20'd1 << $urandom_range(0, 19);
            end
            applyStimulus(($urandom_range(0, 49) == 0), s, $urandom, ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
